fmap_pingpong_ram: RTL and testbench
====================================

# fmap_pingpong_ram

Parametrised multi-channel feature-map buffer. It is the successor to the fixed 16-channel, 16-bit per-layer map RAMs. It holds NUM_CH parallel channel memories of DEPTH words each, duplicated into two banks (ping/pong), so a producer layer can fill one bank while the consumer layer reads the other. Bank ownership is managed by a commit/release handshake with sticky error flags. It sits between a conv/pool stage's write port and the next stage's read port.

## Interface
- NUM_CH, 16, number of parallel channels
- DATA_W, 16, bits per channel word
- DEPTH, 100, words per channel per bank
- ADDR_W, 7, address width; must satisfy 2^ADDR_W >= DEPTH
- clk  in  1  sole clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write word address
- wr_data  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- wr_last  in  1  qualified by wr_en; commits the current write bank
- wr_ready  out  1  current write bank is free
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_W  read word address
- rd_data  out  NUM_CH*DATA_W  read data, same packing as wr_data
- rd_valid  out  1  rd_data holds the result of an accepted read
- rd_avail  out  1  current read bank is full (committed)
- rd_release  in  1  frees the current read bank
- err_ovf  out  1  sticky: write attempted while wr_ready=0
- err_udf  out  1  sticky: read attempted while rd_avail=0

## Operation
- State:
  - bank_full[1:0]
  - wr_sel and rd_sel (1 bit each)
  - storage 2 x NUM_CH x DEPTH x DATA_W; storage is not reset
- wr_ready = !bank_full[wr_sel]; rd_avail = bank_full[rd_sel].
- Accepted write (wr_en & wr_ready & wr_addr<DEPTH): every channel of bank wr_sel is written at wr_addr.
- wr_en & wr_ready & wr_last:
  - the word is written (if in range)
  - bank_full[wr_sel] is set
  - wr_sel toggles
- wr_en & !wr_ready: the write is dropped and err_ovf is set.
- wr_addr>=DEPTH with wr_ready: the data write is dropped, but wr_last still commits.
- Accepted read (rd_en & rd_avail): reads bank rd_sel at rd_addr. rd_addr>=DEPTH returns all-zero data, with rd_valid still asserted.
- rd_en & !rd_avail: no read; err_udf is set; rd_valid stays 0.
- rd_release & rd_avail: bank_full[rd_sel] is cleared and rd_sel toggles. rd_release with rd_avail=0 is ignored and is not an error.
- Simultaneous commit and release in the same cycle are legal and act on different banks. A read in the release cycle is accepted against the old rd_sel.
- Error flags clear only on reset.

## Timing
- Reset values:
  - wr_ready=1, rd_avail=0, rd_valid=0, rd_data=0, err_ovf=0, err_udf=0
  - bank_full=0, wr_sel=0, rd_sel=0
- Read latency is 1 cycle: rd_data and rd_valid register on the edge after an accepted rd_en. rd_valid is low in any cycle without an accepted read, and rd_data holds its last value.
- A write becomes visible to a read from the cycle after the commit, since the bank cannot be read until committed.
- A commit at edge N makes rd_avail=1 from N (combinational off registered bank_full). A release at edge N makes wr_ready=1 from N if the writer is waiting on that bank.
- Throughput: one write and one read per cycle sustained.
- Reset asserted mid-operation:
  - all flags and selectors return to reset values immediately
  - any in-flight rd_valid drops
  - memory contents are undefined-but-stale

## Configuration
- FMAP_PINGPONG_RAM_OUT_REG_EN defined: an extra output register stage follows the memory read.
  - read latency becomes 2 cycles; rd_valid is delayed to match
  - both stages reset to 0
- Undefined: read latency is 1 cycle as above.

## Test plan
- Reset, then write addr 0..99 with channel c data = 16'h0100*c + addr, wr_last at addr 99. Expected: rd_avail=1, wr_ready=1 (bank 1 free). Read addr 5 -> next cycle rd_valid=1 and channel 3 reads 16'h0305.
- Fill bank 0 and bank 1 without release. Expected: wr_ready=0. A third wr_en -> err_ovf=1 and bank 0 addr 0 is unchanged on read-back.
- rd_en before any commit -> err_udf=1, rd_valid=0. rd_release with rd_avail=0 -> no state change.
- Same cycle: commit bank 1 and release bank 0. Expected: bank_full=2'b10, rd_sel=1, wr_sel=0, wr_ready=1, rd_avail=1.
- Read rd_addr=120 on a full bank -> rd_data=0, rd_valid=1. Write wr_addr=110 with wr_last -> bank commits, no storage change.
- Assert rst_n low one cycle after rd_en. Expected: rd_valid=0 and all flags at reset values. Repeat with FMAP_PINGPONG_RAM_OUT_REG_EN defined and check 2-cycle latency.

Source files
------------

// File: rtl/fmap_pingpong_ram.sv
// Ping/pong multi-channel feature-map buffer with commit/release bank handoff.
// Define FMAP_PINGPONG_RAM_OUT_REG_EN to add a second read output register (2-cycle read latency).
module fmap_pingpong_ram #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 100,
  parameter int unsigned ADDR_W = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  input  logic                     wr_last,
  output logic                     wr_ready,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     rd_avail,
  input  logic                     rd_release,
  output logic                     err_ovf,
  output logic                     err_udf
);

  localparam int unsigned W = NUM_CH * DATA_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [1:0]   bank_full, bank_full_nxt;
  logic         wr_sel, wr_sel_nxt;
  logic         rd_sel, rd_sel_nxt;
  logic         err_ovf_q, err_udf_q;
  logic [W-1:0] mem [2][DEPTH];
  logic [W-1:0] rd_data_s1;
  logic         rd_valid_s1;

  logic wr_acc, wr_in_range, commit;
  logic rd_acc, rd_in_range, release_acc;

  assign wr_ready    = !bank_full[wr_sel];
  assign rd_avail    = bank_full[rd_sel];
  assign wr_acc      = wr_en & wr_ready;
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_C;
  assign commit      = wr_acc & wr_last;
  assign rd_acc      = rd_en & rd_avail;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_C;
  assign release_acc = rd_release & rd_avail;

  // Commit needs wr bank empty and release needs rd bank full, so they never hit the same bank.
  always_comb begin
    bank_full_nxt = bank_full;
    wr_sel_nxt    = wr_sel;
    rd_sel_nxt    = rd_sel;
    if (commit) begin
      bank_full_nxt[wr_sel] = 1'b1;
      wr_sel_nxt            = !wr_sel;
    end
    if (release_acc) begin
      bank_full_nxt[rd_sel] = 1'b0;
      rd_sel_nxt            = !rd_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      bank_full <= bank_full_nxt;
      wr_sel    <= wr_sel_nxt;
      rd_sel    <= rd_sel_nxt;
      if (wr_en && !wr_ready) err_ovf_q <= 1'b1;
      if (rd_en && !rd_avail) err_udf_q <= 1'b1;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;

  always_ff @(posedge clk) begin
    if (wr_acc && wr_in_range) mem[wr_sel][wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_s1  <= '0;
      rd_valid_s1 <= 1'b0;
    end else begin
      rd_valid_s1 <= rd_acc;
      if (rd_acc) rd_data_s1 <= rd_in_range ? mem[rd_sel][rd_addr] : '0;
    end
  end

`ifdef FMAP_PINGPONG_RAM_OUT_REG_EN
  logic [W-1:0] rd_data_s2;
  logic         rd_valid_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_s2  <= '0;
      rd_valid_s2 <= 1'b0;
    end else begin
      rd_valid_s2 <= rd_valid_s1;
      if (rd_valid_s1) rd_data_s2 <= rd_data_s1;
    end
  end

  assign rd_data  = rd_data_s2;
  assign rd_valid = rd_valid_s2;
`else
  assign rd_data  = rd_data_s1;
  assign rd_valid = rd_valid_s1;
`endif

endmodule

// File: tb/tb_fmap_pingpong_ram.sv
// Scoreboard bench for fmap_pingpong_ram: random traffic against a frame-queue reference model.
module tb_fmap_pingpong_ram;
  localparam int unsigned NUM_CH = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 100;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned W      = NUM_CH * DATA_W;
`ifdef FMAP_PINGPONG_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [W-1:0]      wr_data = '0;
  logic              wr_last = 1'b0;
  logic              wr_ready;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [W-1:0]      rd_data;
  logic              rd_valid;
  logic              rd_avail;
  logic              rd_release = 1'b0;
  logic              err_ovf;
  logic              err_udf;

  fmap_pingpong_ram #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_avail(rd_avail), .rd_release(rd_release),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: physical bank contents plus a count of committed frames
  // with producer/consumer bank pointers.
  logic [W-1:0] mmem [2][DEPTH];
  int           cnt = 0;
  bit           wp = 1'b0, rp = 1'b0;
  bit           e_ovf = 1'b0, e_udf = 1'b0;

  typedef struct {
    logic [W-1:0] d;
    int           due;
  } exp_t;
  exp_t q[$];

  task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        exp_t m;
        m = q.pop_front();
        total++;
        bad++;
        $display("FAIL read_missed: got no rd_valid expected data %0h at cycle %0d", m.d, m.due);
      end
      if (rd_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rd_valid: got rd_valid=1 expected 0 (data %0h)", rd_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_w("rd_data", rd_data, e.d);
          check_i("rd_latency", cyc, e.due);
        end
      end
    end
  end

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] r;
    for (int unsigned i = 0; i < NUM_CH; i++) r[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return r;
  endfunction

  function automatic logic [W-1:0] pat_word(input int unsigned a);
    logic [W-1:0] r;
    for (int unsigned c = 0; c < NUM_CH; c++) r[c*DATA_W +: DATA_W] = DATA_W'(c * 256 + a);
    return r;
  endfunction

  task automatic step(input logic we, input logic [ADDR_W-1:0] wa, input logic [W-1:0] wd,
                      input logic wl, input logic re, input logic [ADDR_W-1:0] ra,
                      input logic rr);
    bit   ready, avail;
    exp_t e;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_last = wl;
    rd_en = re; rd_addr = ra; rd_release = rr;
    ready = (cnt < 2);
    avail = (cnt > 0);
    if (re) begin
      if (avail) begin
        e.d   = (int'(ra) < int'(DEPTH)) ? mmem[rp][ra] : '0;
        e.due = cyc + LAT;
        q.push_back(e);
      end else begin
        e_udf = 1'b1;
      end
    end
    if (we) begin
      if (!ready) e_ovf = 1'b1;
      else begin
        if (int'(wa) < int'(DEPTH)) mmem[wp][wa] = wd;
        if (wl) begin
          cnt++;
          wp = !wp;
        end
      end
    end
    if (rr && avail) begin
      cnt--;
      rp = !rp;
    end
    @(posedge clk);
    #1;
    check_b("wr_ready", wr_ready, cnt < 2);
    check_b("rd_avail", rd_avail, cnt > 0);
    check_b("err_ovf", err_ovf, e_ovf);
    check_b("err_udf", err_udf, e_udf);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic fill_frame(input bit patterned);
    for (int unsigned a = 0; a < DEPTH; a++)
      step(1'b1, ADDR_W'(a), patterned ? pat_word(a) : rnd_word(), a == DEPTH - 1, 1'b0, '0, 1'b0);
  endtask

  task automatic model_reset();
    q.delete();
    cnt = 0; wp = 1'b0; rp = 1'b0; e_ovf = 1'b0; e_udf = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_b({tag, "_rd_valid"}, rd_valid, 1'b0);
    check_w({tag, "_rd_data"}, rd_data, '0);
    check_b({tag, "_wr_ready"}, wr_ready, 1'b1);
    check_b({tag, "_rd_avail"}, rd_avail, 1'b0);
    check_b({tag, "_err_ovf"}, err_ovf, 1'b0);
    check_b({tag, "_err_udf"}, err_udf, 1'b0);
  endtask

  initial begin
    logic [W-1:0] w;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_outputs("reset");

    // Underflow and ignored release before anything is committed.
    step(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'(3), 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    idle();

    // Fill bank 0 with the recognisable pattern, read address 5.
    fill_frame(1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'(5), 1'b0);
    for (int i = 1; i < LAT; i++) idle();
    check_b("ch3_valid", rd_valid, 1'b1);
    w = rd_data;
    check_w("ch3_data", W'(w[3*DATA_W +: DATA_W]), W'(16'h0305));

    // Fill bank 1; commit it in the same cycle bank 0 is released.
    for (int unsigned a = 0; a < DEPTH - 1; a++)
      step(1'b1, ADDR_W'(a), rnd_word(), 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, ADDR_W'(DEPTH - 1), rnd_word(), 1'b1, 1'b0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'(50), 1'b0);

    // Both banks full: overflow write must not disturb bank 0.
    fill_frame(1'b0);
    step(1'b1, ADDR_W'(0), rnd_word(), 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'(0), 1'b0);

    // Out-of-range read and out-of-range committing write.
    step(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'(120), 1'b0);
    step(1'b1, ADDR_W'(110), rnd_word(), 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'(10), 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'(DEPTH - 1), 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic we, wl, re, rr;
      we = ($urandom_range(0, 1) == 1);
      wl = we && ($urandom_range(0, 39) == 0);
      re = ($urandom_range(0, 1) == 1);
      rr = ($urandom_range(0, 29) == 0);
      step(we, ADDR_W'($urandom_range(0, 127)), rnd_word(), wl,
           re, ADDR_W'($urandom_range(0, 127)), rr);
    end
    for (int i = 0; i < LAT + 1; i++) idle();

    // Reset one cycle after an accepted read.
    if (cnt == 0) fill_frame(1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'($urandom_range(0, DEPTH - 1)), 1'b0);
    rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; rd_release = 1'b0; wr_last = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    check_reset_outputs("midreset_hold");
    rst_n = 1'b1;

    // Post-reset operation: stale storage is still readable after a commit.
    fill_frame(1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'(77), 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'(0), 1'b1);
    for (int i = 0; i < LAT + 2; i++) idle();

    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
